// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte and status strobes out.
// State_Dbg carries the receiver FSM state for external observation.
interface uart_rx_if;
    logic       Serial_In;
    logic [7:0] Data_Out;
    logic       Data_Valid;
    logic       Frame_Err;
    logic       RBusy;
    logic [2:0] State_Dbg;

    // Handshake: no backpressure. Data_Valid is a one-cycle strobe meaning Data_Out changed
    // this cycle; the consumer must capture it before the next good frame overwrites it.
    modport master (
        output Serial_In,
        input  Data_Out, Data_Valid, Frame_Err, RBusy, State_Dbg
    );

    modport slave (
        input  Serial_In,
        output Data_Out, Data_Valid, Frame_Err, RBusy, State_Dbg
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit start qualification, LSB-first data,
// registered Data_Valid / Frame_Err strobes and a break-hold state after a bad stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic     Clk,
    input  logic     RST,
    uart_rx_if.slave rx_if
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync2_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch an immediately following start bit.
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        dout_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            dout_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_if.Serial_In;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_if.Data_Out   = dout_q;
    assign rx_if.Data_Valid = valid_q;
    assign rx_if.Frame_Err  = ferr_q;
    assign rx_if.RBusy      = (state_q != S_IDLE);
    assign rx_if.State_Dbg  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame driver, loopback transmitter model,
// expected-result queue popped on every Data_Valid / Frame_Err strobe.
module tb_uart_rx;
    localparam int CPB = 16;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    uart_rx_if rx_if ();

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .Clk   (clk),
        .RST   (rst_n),
        .rx_if (rx_if)
    );

    logic line_q   = 1'b1;
    logic loop_sel = 1'b0;
    logic tx_line;
    assign rx_if.Serial_In = loop_sel ? tx_line : line_q;

    // scoreboard state: entry = {is_frame_err, expected Data_Out}
    logic [8:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_valid_cyc = 0;
    int busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor
    always @(negedge clk) begin : monitor
        logic [8:0] e;
        if (rst_n) begin
            if (rx_if.RBusy) busy_cnt++;
            if (rx_if.Data_Valid || rx_if.Frame_Err) begin
                chk("pulse_exclusive", 32'(rx_if.Data_Valid & rx_if.Frame_Err), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("pulse_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", 32'(rx_if.Frame_Err), 32'(e[8]));
                    chk("data_out", 32'(rx_if.Data_Out), 32'(e[7:0]));
                end
                if (rx_if.Data_Valid) begin
                    valid_cnt++;
                    last_valid_cyc = cyc;
                end else begin
                    err_cnt++;
                end
            end
        end
    end

    // loopback transmitter model, bit timing advanced on the rising edge
    logic       tx_go   = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [9:0] tx_sh   = 10'h3FF;
    int tx_cnt  = 0;
    int tx_bits = 0;
    assign tx_line = tx_busy ? tx_sh[0] : 1'b1;

    always @(posedge clk) begin
        if (tx_go && !tx_busy) begin
            tx_sh   <= {1'b1, tx_data, 1'b0};
            tx_busy <= 1'b1;
            tx_cnt  <= 0;
            tx_bits <= 0;
        end else if (tx_busy) begin
            if (tx_cnt == CPB - 1) begin
                tx_cnt <= 0;
                tx_sh  <= {1'b1, tx_sh[9:1]};
                if (tx_bits == 9) tx_busy <= 1'b0;
                else tx_bits <= tx_bits + 1;
            end else begin
                tx_cnt <= tx_cnt + 1;
            end
        end
    end

    // driver tasks (called at a falling edge)
    task automatic drive_bit(input logic b, input int clks);
        line_q = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        if (stop_b) begin
            exp_q.push_back({1'b0, d});
            last_good = d;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
        drive_bit(stop_b, CPB);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_data"},  32'(rx_if.Data_Out),   32'h00);
        chk({tag, "_valid"}, 32'(rx_if.Data_Valid), 32'd0);
        chk({tag, "_ferr"},  32'(rx_if.Frame_Err),  32'd0);
        chk({tag, "_busy"},  32'(rx_if.RBusy),      32'd0);
        chk({tag, "_state"}, 32'(rx_if.State_Dbg),  32'd0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int v0, e0, b0, t0, t1, d, n;
        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        drive_bit(1'b1, 2 * CPB);

        // single frame 0xDB, latency and return to idle
        v0 = valid_cnt; e0 = err_cnt; t0 = cyc;
        send_frame(8'hDB, 1'b1);
        drive_bit(1'b1, 2 * CPB);
        wait_drain(400);
        chk("t1_valid_count", 32'(valid_cnt - v0), 32'd1);
        chk("t1_err_count", 32'(err_cnt - e0), 32'd0);
        d = last_valid_cyc - t0;
        chk("t1_latency_in_range", 32'(d >= 154 && d <= 156), 32'd1);
        chk("t1_busy_after", 32'(rx_if.RBusy), 32'd0);
        chk("t1_data_held", 32'(rx_if.Data_Out), 32'hDB);

        // back-to-back frames, no idle gap
        v0 = valid_cnt;
        send_frame(8'h55, 1'b1);
        t1 = last_valid_cyc;
        send_frame(8'hAA, 1'b1);
        drive_bit(1'b1, 2 * CPB);
        wait_drain(400);
        chk("t2_valid_count", 32'(valid_cnt - v0), 32'd2);
        chk("t2_spacing", 32'(last_valid_cyc - t1), 32'(10 * CPB));

        // 4-cycle low glitch is rejected
        v0 = valid_cnt; e0 = err_cnt; b0 = busy_cnt;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 3 * CPB);
        d = busy_cnt - b0;
        chk("t3_busy_len", 32'(d >= 6 && d <= 9), 32'd1);
        chk("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("t3_no_err", 32'(err_cnt - e0), 32'd0);
        chk("t3_busy_after", 32'(rx_if.RBusy), 32'd0);

        // bad stop bit, line held low (break), then a good frame
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 2 * CPB);
        drive_bit(1'b1, 2 * CPB);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1, 2 * CPB);
        wait_drain(400);
        chk("t4_err_count", 32'(err_cnt - e0), 32'd1);
        chk("t4_valid_count", 32'(valid_cnt - v0), 32'd1);
        chk("t4_data", 32'(rx_if.Data_Out), 32'h81);

        // reset in the middle of data bit 4
        v0 = valid_cnt; e0 = err_cnt;
        begin
            logic [7:0] pd;
            pd = 8'hC3;
            drive_bit(1'b0, CPB);
            for (int i = 0; i < 4; i++) drive_bit(pd[i], CPB);
            drive_bit(pd[4], CPB / 2);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("t5_reset");
        line_q = 1'b1;
        last_good = 8'h00;
        rst_n = 1'b1;
        drive_bit(1'b1, 2 * CPB);
        chk("t5_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("t5_no_err", 32'(err_cnt - e0), 32'd0);
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, CPB);
        wait_drain(400);
        chk("t5_data", 32'(rx_if.Data_Out), 32'hA5);

        // loopback from transmitter model
        v0 = valid_cnt;
        loop_sel = 1'b1;
        exp_q.push_back({1'b0, 8'hDB});
        last_good = 8'hDB;
        tx_data = 8'b1101_1011;
        tx_go = 1'b1;
        @(negedge clk);
        tx_go = 1'b0;
        n = 0;
        while (tx_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t6_tx_done", 32'(tx_busy), 32'd0);
        repeat (CPB) @(negedge clk);
        wait_drain(400);
        chk("t6_valid_count", 32'(valid_cnt - v0), 32'd1);
        chk("t6_data", 32'(rx_if.Data_Out), 32'hDB);
        loop_sel = 1'b0;

        repeat (CPB) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
